// File: rtl/calc_pkg.sv
// Shared key codes, ALU op encodings, sequencer states and decoded-key record
// for the calculator sequencer.
package calc_pkg;

  localparam logic [4:0] KEY_ADD   = 5'd10;
  localparam logic [4:0] KEY_MINUS = 5'd11;
  localparam logic [4:0] KEY_MUL   = 5'd12;
  localparam logic [4:0] KEY_DIV   = 5'd13;
  localparam logic [4:0] KEY_EQUAL = 5'd14;
  localparam logic [4:0] KEY_CLEAR = 5'd15;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } aluOpT;

  typedef enum logic [2:0] {
    ENTER_A,
    OPER_WAIT,
    ENTER_B,
    CALC,
    SHOW
  } calcStateT;

  typedef struct packed {
    logic       isDigit;
    logic [3:0] digit;
    logic       isOper;   // add, mul, div
    logic       isMinus;  // minus is either subtract or a sign key
    logic       isEqual;
    logic       isClear;
    aluOpT      operOp;   // op selected by an operator or minus key
  } keyClassT;

  function automatic aluOpT keyToOp(input logic [4:0] code);
    case (code)
      KEY_MINUS: keyToOp = OP_SUB;
      KEY_MUL:   keyToOp = OP_MUL;
      KEY_DIV:   keyToOp = OP_DIV;
      default:   keyToOp = OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/calc_key_decode.sv
// Combinational key classifier: turns a raw key strobe into one-hot key classes.
module calc_key_decode
  import calc_pkg::*;
(
  input  logic     key_valid,
  input  logic [4:0] key_code,
  output keyClassT keyClass
);

  always_comb begin
    keyClass        = '0;
    keyClass.digit  = key_code[3:0];
    keyClass.operOp = keyToOp(key_code);
    if (key_valid) begin
      keyClass.isDigit = (key_code <= 5'd9);
      keyClass.isOper  = (key_code == KEY_ADD) || (key_code == KEY_MUL) || (key_code == KEY_DIV);
      keyClass.isMinus = (key_code == KEY_MINUS);
      keyClass.isEqual = (key_code == KEY_EQUAL);
      keyClass.isClear = (key_code == KEY_CLEAR);
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator key sequencer: builds two signed operands from key presses and
// drives an external ALU. Define NEG_OPERAND_EN to allow a leading minus sign.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 4,
  parameter int DW         = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_valid,
  input  logic [4:0]    key_code,
  output logic          alu_start,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [1:0]    alu_op,
  input  logic          alu_done,
  input  logic [DW-1:0] alu_result,
  output logic [DW-1:0] disp_value,
  output logic          disp_neg_pending,
  output logic          busy
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic signed [DW-1:0] TEN = DW'(10);

  keyClassT                key;
  calcStateT               stateReg;
  calcStateT               effState;
  logic signed [DW-1:0]    opA, opB;
  logic signed [DW-1:0]    digitExt, accA, accB;
  logic [CW-1:0]           cntA, cntB;
  logic                    negA, negB;
  logic                    discardDone;
  logic                    doneHit;
  logic                    minusIsSign;
  logic                    operKey;

  calc_key_decode keyDecode (
    .key_valid (key_valid),
    .key_code  (key_code),
    .keyClass  (key)
  );

  // A completion arriving with a key is applied first, so the key sees SHOW.
  always_comb begin
    doneHit  = (stateReg == CALC) && alu_done && !discardDone;
    effState = doneHit ? SHOW : stateReg;
    digitExt = signed'({{(DW-4){1'b0}}, key.digit});
    accA     = negA ? (opA * TEN - digitExt) : (opA * TEN + digitExt);
    accB     = negB ? (opB * TEN - digitExt) : (opB * TEN + digitExt);
  end

`ifdef NEG_OPERAND_EN
  assign minusIsSign = key.isMinus &&
                       (((effState == ENTER_A) && (cntA == '0)) || (effState == OPER_WAIT));
  assign disp_neg_pending = ((stateReg == ENTER_A) && negA && (cntA == '0)) ||
                            ((stateReg == OPER_WAIT) && negB);
`else
  assign minusIsSign      = 1'b0;
  assign disp_neg_pending = 1'b0;
`endif

  assign operKey = key.isOper || (key.isMinus && !minusIsSign);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg    <= ENTER_A;
      opA         <= '0;
      opB         <= '0;
      cntA        <= '0;
      cntB        <= '0;
      negA        <= 1'b0;
      negB        <= 1'b0;
      discardDone <= 1'b0;
      alu_start   <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= OP_ADD;
      disp_value  <= '0;
      busy        <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      if (alu_done && discardDone)
        discardDone <= 1'b0;
      if (doneHit) begin
        stateReg   <= SHOW;
        opA        <= alu_result;
        disp_value <= alu_result;
        busy       <= 1'b0;
      end

      if (key.isClear) begin
        stateReg   <= ENTER_A;
        opA        <= '0;
        opB        <= '0;
        cntA       <= '0;
        cntB       <= '0;
        negA       <= 1'b0;
        negB       <= 1'b0;
        disp_value <= '0;
        busy       <= 1'b0;
        // The abandoned operation will still complete; swallow that pulse.
        if ((stateReg == CALC) && !doneHit)
          discardDone <= 1'b1;
      end else begin
        case (effState)
          ENTER_A: begin
            if (key.isDigit) begin
              if (cntA < CW'(MAX_DIGITS)) begin
                opA        <= accA;
                cntA       <= cntA + 1'b1;
                disp_value <= accA;
              end
            end else if (minusIsSign) begin
              negA <= ~negA;
            end else if (operKey && (cntA != '0)) begin
              alu_op   <= key.operOp;
              stateReg <= OPER_WAIT;
              opB      <= '0;
              cntB     <= '0;
              negB     <= 1'b0;
            end
          end
          OPER_WAIT: begin
            if (key.isDigit) begin
              opB        <= accB;
              cntB       <= CW'(1);
              disp_value <= accB;
              stateReg   <= ENTER_B;
            end else if (minusIsSign) begin
              negB <= ~negB;
            end else if (operKey) begin
              alu_op <= key.operOp;
            end
          end
          ENTER_B: begin
            if (key.isDigit) begin
              if (cntB < CW'(MAX_DIGITS)) begin
                opB        <= accB;
                cntB       <= cntB + 1'b1;
                disp_value <= accB;
              end
            end else if (key.isEqual && (cntB != '0)) begin
              alu_start  <= 1'b1;
              alu_a      <= opA;
              alu_b      <= opB;
              busy       <= 1'b1;
              disp_value <= opA;
              stateReg   <= CALC;
            end
          end
          SHOW: begin
            if (key.isDigit) begin
              opA        <= digitExt;
              cntA       <= CW'(1);
              negA       <= 1'b0;
              disp_value <= digitExt;
              stateReg   <= ENTER_A;
            end else if (operKey) begin
              alu_op   <= key.operOp;
              stateReg <= OPER_WAIT;
              opB      <= '0;
              cntB     <= '0;
              negB     <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with hand-computed operands and results.
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          key_valid;
  logic [4:0]    key_code;
  logic          alu_start;
  logic [DW-1:0] alu_a, alu_b;
  logic [1:0]    alu_op;
  logic          alu_done;
  logic [DW-1:0] alu_result;
  logic [DW-1:0] disp_value;
  logic          disp_neg_pending;
  logic          busy;

  int checkCount = 0;
  int errorCount = 0;
  int startCount = 0;
  int capA = 0, capB = 0, capOp = 0;

  calc_sequencer #(.MAX_DIGITS(4), .DW(DW)) dut (
    .clk              (clk),
    .rst              (rst),
    .key_valid        (key_valid),
    .key_code         (key_code),
    .alu_start        (alu_start),
    .alu_a            (alu_a),
    .alu_b            (alu_b),
    .alu_op           (alu_op),
    .alu_done         (alu_done),
    .alu_result       (alu_result),
    .disp_value       (disp_value),
    .disp_neg_pending (disp_neg_pending),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (alu_start) begin
      startCount = startCount + 1;
      capA  = int'($signed(alu_a));
      capB  = int'($signed(alu_b));
      capOp = int'(alu_op);
    end
  end

  task automatic checkVal(input string tag, input int got, input int exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic pressKey(input int code);
    key_valid = 1'b1;
    key_code  = code[4:0];
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = '0;
    @(negedge clk);
  endtask

  task automatic pulseDone(input int res);
    alu_done   = 1'b1;
    alu_result = res[DW-1:0];
    @(negedge clk);
    alu_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic checkIdle(input string tag);
    checkVal({tag, "_disp"}, int'(disp_value), 0);
    checkVal({tag, "_busy"}, int'(busy), 0);
    checkVal({tag, "_start"}, int'(alu_start), 0);
    checkVal({tag, "_a"}, int'(alu_a), 0);
    checkVal({tag, "_b"}, int'(alu_b), 0);
    checkVal({tag, "_op"}, int'(alu_op), 0);
    checkVal({tag, "_negpend"}, int'(disp_neg_pending), 0);
  endtask

  initial begin
    int prevStarts;
    rst = 1'b1;
    key_valid = 1'b0;
    key_code = '0;
    alu_done = 1'b0;
    alu_result = '0;
    repeat (3) @(negedge clk);
    checkIdle("reset");
    rst = 1'b0;
    @(negedge clk);

    // 12 + 3
    pressKey(1); pressKey(2);
    checkVal("entA_disp", int'(disp_value), 12);
    pressKey(10); pressKey(3);
    checkVal("entB_disp", int'(disp_value), 3);
    pressKey(14);
    checkVal("add_starts", startCount, 1);
    checkVal("add_a", capA, 12);
    checkVal("add_b", capB, 3);
    checkVal("add_op", capOp, 0);
    checkVal("calc_busy", int'(busy), 1);
    checkVal("calc_disp", int'(disp_value), 12);
    pressKey(7);
    checkVal("calc_key_ignored", int'(disp_value), 12);
    checkVal("calc_a_held", int'($signed(alu_a)), 12);
    pulseDone(15);
    checkVal("show_disp", int'(disp_value), 15);
    checkVal("show_busy", int'(busy), 0);
    checkVal("add_starts_once", startCount, 1);

    // chain 15 - 5, then reset mid-calc
    pressKey(11); pressKey(5); pressKey(14);
    checkVal("sub_starts", startCount, 2);
    checkVal("sub_a", capA, 15);
    checkVal("sub_b", capB, 5);
    checkVal("sub_op", capOp, 1);
    rst = 1'b1;
    #1;
    checkIdle("midcalc_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulseDone(10);
    checkVal("post_rst_done_disp", int'(disp_value), 0);
    checkVal("post_rst_done_busy", int'(busy), 0);
    pressKey(3);
    checkVal("post_rst_digit", int'(disp_value), 3);

    // digit limit
    pressKey(15);
    pressKey(1); pressKey(2); pressKey(3); pressKey(4); pressKey(5);
    checkVal("max_digits", int'(disp_value), 1234);
    pressKey(20);
    checkVal("code20_ignored", int'(disp_value), 1234);

    // clear during calc discards the result
    pressKey(15);
    pressKey(9); pressKey(13); pressKey(4); pressKey(14);
    checkVal("div_starts", startCount, 3);
    checkVal("div_op", capOp, 3);
    pressKey(15);
    checkVal("clr_calc_disp", int'(disp_value), 0);
    checkVal("clr_calc_busy", int'(busy), 0);
    pulseDone(2);
    checkVal("discard_disp", int'(disp_value), 0);
    pressKey(7);
    checkVal("after_discard_digit", int'(disp_value), 7);
    prevStarts = startCount;
    pressKey(14);
    checkVal("equal_in_A_ignored", startCount, prevStarts);

    // operator replacement and equal in OPER_WAIT
    pressKey(15);
    pressKey(6); pressKey(10); pressKey(12); pressKey(14);
    checkVal("equal_operwait_ignored", startCount, prevStarts);
    pressKey(2); pressKey(14);
    checkVal("mul_starts", startCount, prevStarts + 1);
    checkVal("mul_a", capA, 6);
    checkVal("mul_b", capB, 2);
    checkVal("mul_op", capOp, 2);
    pulseDone(12);
    checkVal("mul_show", int'(disp_value), 12);
    pressKey(4);
    checkVal("show_digit_newA", int'(disp_value), 4);

    // done and operator in the same cycle: result becomes A, then chain
    pressKey(15);
    pressKey(2); pressKey(10); pressKey(3); pressKey(14);
    alu_done = 1'b1;
    alu_result = 16'd5;
    key_valid = 1'b1;
    key_code = 5'd12;
    @(negedge clk);
    alu_done = 1'b0;
    key_valid = 1'b0;
    key_code = '0;
    @(negedge clk);
    checkVal("same_cycle_disp", int'(disp_value), 5);
    pressKey(4); pressKey(14);
    checkVal("chain_a", capA, 5);
    checkVal("chain_b", capB, 4);
    checkVal("chain_op", capOp, 2);
    pulseDone(20);

    // leading minus
    pressKey(15);
    pressKey(11);
`ifdef NEG_OPERAND_EN
    checkVal("neg_pending", int'(disp_neg_pending), 1);
    pressKey(7);
    checkVal("neg_disp", int'($signed(disp_value)), -7);
    checkVal("neg_pending_clr", int'(disp_neg_pending), 0);
    pressKey(12); pressKey(11); pressKey(2); pressKey(14);
    checkVal("neg_a", capA, -7);
    checkVal("neg_b", capB, -2);
    checkVal("neg_op", capOp, 2);
    pulseDone(14);
`else
    checkVal("minus_no_pending", int'(disp_neg_pending), 0);
    pressKey(7);
    checkVal("minus_ignored_disp", int'($signed(disp_value)), 7);
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
